// File: rtl/conv2d.sv
// Sequential NCHW 2-D convolution: one kernel tap per cycle, one write cycle per output point.
// Weights are fixed at 1 and biases at 0, so no coefficient storage or ports are needed.
module conv2d #(
   parameter int BATCH_SIZE   = 1,
   parameter int IN_CHANNELS  = 2,
   parameter int OUT_CHANNELS = 1,
   parameter int IN_HEIGHT    = 4,
   parameter int IN_WIDTH     = 4,
   parameter int KERNEL_SIZE  = 2,
   parameter int STRIDE       = 2,
   parameter int PADDING      = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  done,
   output logic                  valid,
   output logic [ADDR_WIDTH-1:0] input_addr,
   input  logic [DATA_WIDTH-1:0] input_data,
   output logic                  input_en,
   output logic [ADDR_WIDTH-1:0] output_addr,
   output logic [DATA_WIDTH-1:0] output_data,
   output logic                  output_we,
   output logic                  output_en
);

   localparam int OutH = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
   localparam int OutW = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
   localparam int CntW = 16;
   localparam logic [DATA_WIDTH-1:0] Weight = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] Bias   = '0;

   typedef enum logic [1:0] {StIdle, StCompute, StWrite, StDone} state_e;

   state_e state_q, state_d;
   logic [CntW-1:0] b_q, b_d, oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
   logic [CntW-1:0] c_q, c_d, ky_q, ky_d, kx_q, kx_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;

   int iy, ix;
   logic in_bounds;
   logic [ADDR_WIDTH-1:0] tap_addr, pt_addr;
   logic [DATA_WIDTH-1:0] prod;
   logic last_kx, last_ky, last_c, last_tap;
   logic last_ox, last_oy, last_oc, last_b, last_pt;

   // Tap coordinates may go negative or past the edge when PADDING > 0.
   always_comb begin
      iy = int'(oy_q) * STRIDE + int'(ky_q) - PADDING;
      ix = int'(ox_q) * STRIDE + int'(kx_q) - PADDING;
      in_bounds = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
      tap_addr = ADDR_WIDTH'(((int'(b_q) * IN_CHANNELS + int'(c_q)) * IN_HEIGHT + iy)
                             * IN_WIDTH + ix);
      pt_addr = ADDR_WIDTH'(((int'(b_q) * OUT_CHANNELS + int'(oc_q)) * OutH + int'(oy_q))
                            * OutW + int'(ox_q));
      prod = input_data * Weight;
      last_kx  = (kx_q == CntW'(KERNEL_SIZE - 1));
      last_ky  = (ky_q == CntW'(KERNEL_SIZE - 1));
      last_c   = (c_q == CntW'(IN_CHANNELS - 1));
      last_tap = last_kx && last_ky && last_c;
      last_ox  = (ox_q == CntW'(OutW - 1));
      last_oy  = (oy_q == CntW'(OutH - 1));
      last_oc  = (oc_q == CntW'(OUT_CHANNELS - 1));
      last_b   = (b_q == CntW'(BATCH_SIZE - 1));
      last_pt  = last_ox && last_oy && last_oc && last_b;
   end

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      oc_d        = oc_q;
      oy_d        = oy_q;
      ox_d        = ox_q;
      c_d         = c_q;
      ky_d        = ky_q;
      kx_d        = kx_q;
      acc_d       = acc_q;
      done        = 1'b0;
      valid       = 1'b0;
      input_en    = 1'b0;
      input_addr  = '0;
      output_addr = '0;
      output_data = '0;
      output_we   = 1'b0;
      output_en   = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            done = (state_q == StDone);
            if (start) begin
               state_d = StCompute;
               b_d     = '0;
               oc_d    = '0;
               oy_d    = '0;
               ox_d    = '0;
               c_d     = '0;
               ky_d    = '0;
               kx_d    = '0;
               acc_d   = '0;
            end
         end
         StCompute: begin
            input_en   = in_bounds;
            input_addr = in_bounds ? tap_addr : '0;
            acc_d      = acc_q + (in_bounds ? prod : '0);
            if (last_kx) begin
               kx_d = '0;
               if (last_ky) begin
                  ky_d = '0;
                  c_d  = last_c ? '0 : c_q + CntW'(1);
               end else begin
                  ky_d = ky_q + CntW'(1);
               end
            end else begin
               kx_d = kx_q + CntW'(1);
            end
            if (last_tap) state_d = StWrite;
         end
         StWrite: begin
            valid       = 1'b1;
            output_we   = 1'b1;
            output_en   = 1'b1;
            output_addr = pt_addr;
            output_data = acc_q + Bias;
            acc_d       = '0;
            if (last_ox) begin
               ox_d = '0;
               if (last_oy) begin
                  oy_d = '0;
                  if (last_oc) begin
                     oc_d = '0;
                     b_d  = last_b ? '0 : b_q + CntW'(1);
                  end else begin
                     oc_d = oc_q + CntW'(1);
                  end
               end else begin
                  oy_d = oy_q + CntW'(1);
               end
            end else begin
               ox_d = ox_q + CntW'(1);
            end
            state_d = last_pt ? StDone : StCompute;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         b_q     <= '0;
         oc_q    <= '0;
         oy_q    <= '0;
         ox_q    <= '0;
         c_q     <= '0;
         ky_q    <= '0;
         kx_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         oc_q    <= oc_d;
         oy_q    <= oy_d;
         ox_q    <= ox_d;
         c_q     <= c_d;
         ky_q    <= ky_d;
         kx_q    <= kx_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_conv2d.sv
// Directed bench for conv2d: default 2x4x4 -> 2x2 instance plus a padded 3x3 instance.
// Writes are logged by posedge monitors; the initial block compares against hand values.
module tb_conv2d;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, p_start;
   int n_tests = 0;
   int n_fail  = 0;

   // Default instance
   logic        done, valid, input_en, output_we, output_en;
   logic [15:0] input_addr, output_addr;
   logic [31:0] input_data, output_data;

   assign input_data = (input_addr < 16'd32) ? {16'd0, input_addr} : 32'hBAD0_0000;

   conv2d u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .done       (done),
      .valid      (valid),
      .input_addr (input_addr),
      .input_data (input_data),
      .input_en   (input_en),
      .output_addr(output_addr),
      .output_data(output_data),
      .output_we  (output_we),
      .output_en  (output_en)
   );

   // Padded instance: 1x3x3 input, K=3, stride 1, pad 1
   logic        p_done, p_valid, p_input_en, p_output_we, p_output_en;
   logic [15:0] p_input_addr, p_output_addr;
   logic [31:0] p_input_data, p_output_data;

   assign p_input_data = (p_input_addr < 16'd9) ? 32'd1 : 32'hBAD0_0000;

   conv2d #(
      .BATCH_SIZE  (1),
      .IN_CHANNELS (1),
      .OUT_CHANNELS(1),
      .IN_HEIGHT   (3),
      .IN_WIDTH    (3),
      .KERNEL_SIZE (3),
      .STRIDE      (1),
      .PADDING     (1),
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (16)
   ) u_pad (
      .clk        (clk),
      .rst        (rst),
      .start      (p_start),
      .done       (p_done),
      .valid      (p_valid),
      .input_addr (p_input_addr),
      .input_data (p_input_data),
      .input_en   (p_input_en),
      .output_addr(p_output_addr),
      .output_data(p_output_data),
      .output_we  (p_output_we),
      .output_en  (p_output_en)
   );

   // Write logs
   int          n_wr = 0;
   logic [15:0] log_addr [64];
   logic [31:0] log_data [64];
   logic        log_vld  [64];
   int          p_n_wr = 0;
   int          p_en_cnt = 0;
   int          p_bad_cnt = 0;
   logic [15:0] p_log_addr [16];
   logic [31:0] p_log_data [16];

   always @(posedge clk) begin
      if (output_we && output_en) begin
         if (n_wr < 64) begin
            log_addr[n_wr] <= output_addr;
            log_data[n_wr] <= output_data;
            log_vld[n_wr]  <= valid;
         end
         n_wr <= n_wr + 1;
      end
      if (p_output_we && p_output_en) begin
         if (p_n_wr < 16) begin
            p_log_addr[p_n_wr] <= p_output_addr;
            p_log_data[p_n_wr] <= p_output_data;
         end
         p_n_wr <= p_n_wr + 1;
      end
      if (p_input_en) begin
         p_en_cnt <= p_en_cnt + 1;
         if (p_input_addr >= 16'd9) p_bad_cnt <= p_bad_cnt + 1;
      end
   end

   int exp_def [4] = '{84, 100, 148, 164};
   int exp_pad [9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One full default run; hold keeps start high until done is seen.
   task automatic run_default(input string tag, input bit hold);
      int base;
      int cyc;
      base  = n_wr;
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      check($sformatf("%s first_en", tag), {31'd0, input_en}, 32'd1);
      check($sformatf("%s first_addr", tag), {16'd0, input_addr}, 32'd0);
      check($sformatf("%s compute_valid", tag), {31'd0, valid}, 32'd0);
      cyc = 0;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
      start = 1'b0;
      check($sformatf("%s cycles", tag), 32'(cyc), 32'd36);
      check($sformatf("%s writes", tag), 32'(n_wr - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < 64) begin
            check($sformatf("%s addr%0d", tag, i), {16'd0, log_addr[base+i]}, 32'(i));
            check($sformatf("%s data%0d", tag, i), log_data[base+i], 32'(exp_def[i]));
            check($sformatf("%s vld%0d", tag, i), {31'd0, log_vld[base+i]}, 32'd1);
         end
      end
      repeat (3) tick();
      check($sformatf("%s done_hold", tag), {31'd0, done}, 32'd1);
      check($sformatf("%s idle_we", tag), {31'd0, output_we}, 32'd0);
      check($sformatf("%s idle_iaddr", tag), {16'd0, input_addr}, 32'd0);
   endtask

   initial begin
      int base;
      int pbase;
      int ebase;
      int cyc;
      rst     = 1'b1;
      start   = 1'b0;
      p_start = 1'b0;
      repeat (2) tick();
      check("rst done", {31'd0, done}, 32'd0);
      check("rst valid", {31'd0, valid}, 32'd0);
      check("rst in_en", {31'd0, input_en}, 32'd0);
      check("rst out_en", {31'd0, output_en}, 32'd0);
      check("rst out_we", {31'd0, output_we}, 32'd0);
      check("rst in_addr", {16'd0, input_addr}, 32'd0);
      check("rst out_addr", {16'd0, output_addr}, 32'd0);
      check("rst out_data", output_data, 32'd0);
      rst = 1'b0;
      tick();

      run_default("runA", 1'b0);
      run_default("runB_fromdone", 1'b0);
      run_default("runC_hold", 1'b1);

      // Re-pulse start mid-run
      base  = n_wr;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 6 + 12;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
      check("repulse cycles", 32'(cyc), 32'd36);
      check("repulse writes", 32'(n_wr - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < 64)
            check($sformatf("repulse data%0d", i), log_data[base+i], 32'(exp_def[i]));
      end

      // Abort with reset in the 10th cycle after start
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      base = n_wr;
      check("abort done", {31'd0, done}, 32'd0);
      check("abort in_en", {31'd0, input_en}, 32'd0);
      check("abort in_addr", {16'd0, input_addr}, 32'd0);
      check("abort out_data", output_data, 32'd0);
      repeat (20) tick();
      check("abort no_writes", 32'(n_wr - base), 32'd0);
      check("abort done_low", {31'd0, done}, 32'd0);
      run_default("runD_restart", 1'b0);

      // Padded instance
      pbase   = p_n_wr;
      ebase   = p_en_cnt;
      p_start = 1'b1;
      tick();
      p_start = 1'b0;
      check("pad first_tap_en", {31'd0, p_input_en}, 32'd0);
      cyc = 0;
      while (!p_done && cyc < 300) begin
         tick();
         cyc++;
      end
      check("pad cycles", 32'(cyc), 32'd90);
      check("pad writes", 32'(p_n_wr - pbase), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (pbase + i < 16) begin
            check($sformatf("pad addr%0d", i), {16'd0, p_log_addr[pbase+i]}, 32'(i));
            check($sformatf("pad data%0d", i), p_log_data[pbase+i], 32'(exp_pad[i]));
         end
      end
      check("pad en_taps", 32'(p_en_cnt - ebase), 32'd49);
      check("pad bad_addr", 32'(p_bad_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv2d.md
CONV2D -- requirements
Module: conv2d

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be supported:
- BATCH_SIZE 1: images per run
- IN_CHANNELS 2: input channels
- OUT_CHANNELS 1: output channels
- IN_HEIGHT 4, IN_WIDTH 4: input spatial size
- KERNEL_SIZE 2: square kernel edge K
- STRIDE 2: window step
- PADDING 0: zero border width
- DATA_WIDTH 32: data bits
- ADDR_WIDTH 16: memory address bits
REQ-002 Derived sizes SHALL be OH=(IN_HEIGHT+2*PADDING-K)/STRIDE+1 and OW=(IN_WIDTH+2*PADDING-K)/STRIDE+1, using integer division.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk in 1: single clock, all state on rising edge
- rst in 1: synchronous, active-high reset
- start in 1: begin a run
- done out 1: run complete
- valid out 1: output_data holds a finished result
- input_addr out ADDR_WIDTH: input tensor read address
- input_data in DATA_WIDTH: read data, combinational from input_addr in the same cycle
- input_en out 1: read enable
- output_addr out ADDR_WIDTH: result write address
- output_data out DATA_WIDTH: result value
- output_we out 1: write enable
- output_en out 1: output memory enable
REQ-004 Tensors SHALL be NCHW row-major.
- Input index: ((b*IN_CHANNELS+c)*IN_HEIGHT+y)*IN_WIDTH+x.
- Output index: ((b*OUT_CHANNELS+oc)*OH+oy)*OW+ox.

Function
REQ-005 Weights SHALL be internal constants: OUT_CHANNELS*IN_CHANNELS*K*K entries, all equal to 1. Biases SHALL be OUT_CHANNELS entries, all equal to 0. There SHALL be no weight or bias ports.
REQ-006 The FSM SHALL have four states: IDLE, COMPUTE, WRITE, DONE.
- IDLE -> COMPUTE when start=1.
- COMPUTE -> WRITE after the last tap of the current output point.
- WRITE -> COMPUTE for the next point, or WRITE -> DONE after the last point.
- DONE -> COMPUTE when start=1.
REQ-007 Point order SHALL be b, then oc, then oy, then ox, with ox innermost. Within a point, taps SHALL be ordered c, then ky, then kx, with kx innermost.
REQ-008 COMPUTE SHALL take one tap per cycle. Input coordinates SHALL be iy=oy*STRIDE+ky-PADDING and ix=ox*STRIDE+kx-PADDING.
- In bounds: input_en=1, input_addr=index, and the accumulator adds input_data*weight in the same cycle.
- Out of bounds (padding): input_en=0 and the tap adds 0.
REQ-009 The accumulator SHALL clear at the start of each point. Arithmetic SHALL be two's-complement DATA_WIDTH, and products and sums SHALL wrap modulo 2^DATA_WIDTH.
REQ-010 WRITE SHALL last exactly one cycle. During it:
- output_en=output_we=valid=1
- output_addr = the point's output index
- output_data = accumulator + bias[oc]
REQ-011 output_en, output_we and valid SHALL be 0 in every state other than WRITE.
REQ-012 done SHALL be 1 only in DONE and SHALL stay high until the next start or rst.
REQ-013 Latency SHALL be as follows:
- The first tap address appears in the cycle after start is sampled.
- Each point costs IN_CHANNELS*K*K + 1 cycles.
- done rises the cycle after the final WRITE.
- With default parameters: 4 points x 9 cycles = 36 cycles, then done.
REQ-014 start SHALL be ignored while in COMPUTE or WRITE.
REQ-015 When idle, input_addr and output_addr SHALL be 0 and input_en SHALL be 0.

Reset
REQ-016 When rst=1 at a rising edge, the following SHALL all happen on that edge:
- state -> IDLE
- all counters and the accumulator -> 0
- done, valid, input_en, output_en, output_we -> 0
- input_addr, output_addr, output_data -> 0
REQ-017 rst SHALL take priority over start. Reset during COMPUTE or WRITE SHALL abort the run with no further writes.

Verification
REQ-018 Defaults, input_mem[i]=i for i=0..31, one-cycle start -> outputs [0..3] = 84, 100, 148, 164 and done high after 36 cycles.
REQ-019 Defaults -> exactly 4 write cycles, each with valid=output_we=output_en=1, at addresses 0, 1, 2, 3 in order.
REQ-020 start held high or re-pulsed during COMPUTE -> run unaffected, results unchanged.
REQ-021 rst asserted in the 10th cycle after start, then restart -> no write after the reset, and the correct results 84, 100, 148, 164 after the restart.
REQ-022 IN_CHANNELS=1, IN 3x3, K=3, STRIDE=1, PADDING=1, input all 1s -> 3x3 output of 4, 6, 4 / 6, 9, 6 / 4, 6, 4, with input_en=0 on every padding tap.
REQ-023 Start issued again from DONE -> identical results produced a second time.
